// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: run/step clock-enable scheduler for the schoolMIPS core.
// Issues single-cycle cpuEn pulses from a prescaled tick, continuously (RUN),
// for a counted number of instructions (BURST/STEP) or not at all (HALT),
// with an optional instruction-address breakpoint.
module sm_clk_ctrl #(
    parameter int SHIFT = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       devide,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [CNT_W-1:0] cmdCount,
    input  logic             stop,
    input  logic             bpEnable,
    input  logic [31:0]      bpAddr,
    input  logic [31:0]      pcAddr,
    output logic             cpuEn,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remaining,
    output logic             bpHit
);

    localparam int PW = SHIFT + 15;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_BURST = 2'd3;

    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] mask;
    logic          tick;
    logic          accept;
    logic          armed;
    logic          bp_match;

    // Tick decode, command handshake, breakpoint compare and pulse gating
    always_comb begin
        mask     = '1;
        mask     = mask >> (4'd15 - devide);
        tick     = (pre_cnt & mask) == mask;
        cmdReady = !stop && (state != ST_BURST);
        accept   = cmdValid && cmdReady;
        bp_match = bpEnable && armed && (pcAddr == bpAddr);
        cpuEn    = tick && (state != ST_HALT) && !stop && !bp_match && !accept;
    end

    // Prescaler: restarts on every accepted command, free-runs while not halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (accept) begin
            pre_cnt <= '0;
        end else if (state != ST_HALT) begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Run/burst control: stop > command accept > breakpoint > burst completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HALT;
            remaining <= '0;
            bpHit     <= 1'b0;
            armed     <= 1'b0;
        end else if (stop) begin
            state     <= ST_HALT;
            remaining <= '0;
        end else if (accept) begin
            bpHit <= 1'b0;
            armed <= 1'b0;
            case (cmdOp)
                OP_HALT: state <= ST_HALT;
                OP_RUN:  state <= ST_RUN;
                OP_STEP: begin
                    state     <= ST_BURST;
                    remaining <= CNT_W'(1);
                end
                OP_BURST: begin
                    if (cmdCount == '0) begin
                        state <= ST_HALT;
                    end else begin
                        state     <= ST_BURST;
                        remaining <= cmdCount;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end else if ((state != ST_HALT) && tick && bp_match) begin
            state     <= ST_HALT;
            remaining <= '0;
            bpHit     <= 1'b1;
        end else if (cpuEn) begin
            armed <= 1'b1;
            if (state == ST_BURST) begin
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: directed scenarios with fixed expectations plus a
// randomized run checked against a behavioural model of the controller.
module tb_sm_clk_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       devide = '0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [1:0]       cmdOp = '0;
    logic [CNT_W-1:0] cmdCount = '0;
    logic             stop = 1'b0;
    logic             bpEnable = 1'b0;
    logic [31:0]      bpAddr = '0;
    logic [31:0]      pcAddr = '0;
    logic             cpuEn;
    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             bpHit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm_clk_ctrl #(.SHIFT(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .devide(devide),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdCount(cmdCount),
        .stop(stop), .bpEnable(bpEnable), .bpAddr(bpAddr), .pcAddr(pcAddr),
        .cpuEn(cpuEn), .state(state), .remaining(remaining), .bpHit(bpHit)
    );

    // Reference model: cycles since last accept, mode, pulses left, sticky flags
    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_rem;
    logic             m_bp, m_armed;
    int               m_cnt;
    logic             e_ready, e_tick, e_acc, e_bpm, e_en;

    // Expected combinational outputs: a tick is the last cycle of each period
    always_comb begin
        e_ready = !stop && (m_state != 2'd2);
        e_tick  = (m_cnt % (1 << devide)) == ((1 << devide) - 1);
        e_acc   = cmdValid && e_ready;
        e_bpm   = bpEnable && m_armed && (pcAddr == bpAddr);
        e_en    = e_tick && (m_state != 2'd0) && !stop && !e_bpm && !e_acc;
    end

    // Model update per clock, applying the priority rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 2'd0; m_rem <= '0; m_bp <= 1'b0; m_armed <= 1'b0; m_cnt <= 0;
        end else begin
            m_cnt <= e_acc ? 0 : ((m_state != 2'd0) ? (m_cnt + 1) % 32768 : m_cnt);
            if (stop) begin
                m_state <= 2'd0; m_rem <= '0;
            end else if (e_acc) begin
                m_bp <= 1'b0; m_armed <= 1'b0;
                if (cmdOp == 2'd0) m_state <= 2'd0;
                else if (cmdOp == 2'd1) m_state <= 2'd1;
                else if (cmdOp == 2'd2) begin m_state <= 2'd2; m_rem <= 1; end
                else if (cmdCount == 0) m_state <= 2'd0;
                else begin m_state <= 2'd2; m_rem <= cmdCount; end
            end else if (m_state != 2'd0 && e_tick && e_bpm) begin
                m_state <= 2'd0; m_rem <= '0; m_bp <= 1'b1;
            end else if (e_en) begin
                m_armed <= 1'b1;
                if (m_state == 2'd2) begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_state <= 2'd0;
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        cmdOp = op; cmdCount = cnt; cmdValid = 1'b1;
        next_cycle;
        cmdValid = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cpuEn, state, remaining, bpHit} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b st=%0d rem=%0d bp=%b want all zero", cpuEn, state, remaining, bpHit);
        end
        next_cycle;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmdReady !== 1'b1 || state !== 2'd0) begin
            failures++;
            $display("FAIL reset_ready got rdy=%b st=%0d want rdy=1 st=0", cmdReady, state);
        end
        next_cycle;
    endtask

    task automatic test_run;
        devide = 4'd0;
        issue(2'd1, '0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) begin cmdOp = 2'd0; cmdValid = 1'b1; end
            @(negedge clk);
            checks++;
            if (cpuEn !== (i < 10)) begin
                failures++;
                $display("FAIL run_pulse cycle=%0d got en=%b want %b", i, cpuEn, (i < 10));
            end
            next_cycle;
        end
        cmdValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cpuEn !== 1'b0 || state !== 2'd0) begin
                failures++;
                $display("FAIL run_halted got en=%b st=%0d want en=0 st=0", cpuEn, state);
            end
            next_cycle;
        end
    endtask

    task automatic test_burst;
        logic [CNT_W-1:0] exp_rem;
        logic             exp_en, exp_rdy;
        logic [1:0]       exp_st;
        devide = 4'd2;
        issue(2'd3, CNT_W'(3));
        for (int i = 1; i <= 14; i++) begin
            cmdOp = 2'd1;
            cmdValid = (i >= 2 && i <= 6);
            exp_en  = (i == 4 || i == 8 || i == 12);
            exp_rem = (i <= 4) ? 3 : (i <= 8) ? 2 : (i <= 12) ? 1 : 0;
            exp_st  = (i <= 12) ? 2'd2 : 2'd0;
            exp_rdy = (i >= 13);
            @(negedge clk);
            checks++;
            if ({cpuEn, state, remaining, cmdReady} !== {exp_en, exp_st, exp_rem, exp_rdy}) begin
                failures++;
                $display("FAIL burst_cycle cycle=%0d got en=%b st=%0d rem=%0d rdy=%b want en=%b st=%0d rem=%0d rdy=%b",
                         i, cpuEn, state, remaining, cmdReady, exp_en, exp_st, exp_rem, exp_rdy);
            end
            next_cycle;
        end
        cmdValid = 1'b0;
    endtask

    task automatic test_breakpoint;
        logic [31:0] seen[$];
        logic        was;
        devide = 4'd1; bpAddr = 32'h10; bpEnable = 1'b1; pcAddr = '0;
        issue(2'd1, '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpuEn) seen.push_back(pcAddr);
            was = cpuEn;
            next_cycle;
            if (was) pcAddr = pcAddr + 4;
        end
        checks++;
        if (seen.size() != 4 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8 || seen[3] !== 32'hC) begin
            failures++;
            $display("FAIL bp_pulses got count=%0d want 4 pulses at 0,4,8,c", seen.size());
        end
        checks++;
        if (bpHit !== 1'b1 || state !== 2'd0) begin
            failures++;
            $display("FAIL bp_halt got bp=%b st=%0d want bp=1 st=0", bpHit, state);
        end
        seen.delete();
        issue(2'd2, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpuEn) seen.push_back(pcAddr);
            was = cpuEn;
            next_cycle;
            if (was) pcAddr = pcAddr + 4;
        end
        checks++;
        if (seen.size() != 1 || seen[0] !== 32'h10) begin
            failures++;
            $display("FAIL bp_step got count=%0d want one pulse at 0x10", seen.size());
        end
        checks++;
        if (bpHit !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL bp_cleared got bp=%b st=%0d want bp=0 st=0", bpHit, state);
        end
        bpEnable = 1'b0;
    endtask

    task automatic test_burst_zero;
        int pulses = 0;
        int busy = 0;
        devide = 4'd0;
        issue(2'd3, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpuEn) pulses++;
            if (state != 2'd0) busy++;
            next_cycle;
        end
        checks++;
        if (pulses != 0 || busy != 0) begin
            failures++;
            $display("FAIL burst_zero got pulses=%0d busy=%0d want 0 and 0", pulses, busy);
        end
        pulses = 0;
        issue(2'd2, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpuEn) pulses++;
            next_cycle;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL step_once got pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_stop;
        devide = 4'd0;
        issue(2'd3, CNT_W'(5));
        stop = 1'b1; cmdOp = 2'd1; cmdValid = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, remaining, cpuEn, cmdReady} !== {2'd2, CNT_W'(5), 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_cycle got st=%0d rem=%0d en=%b rdy=%b want st=2 rem=5 en=0 rdy=0", state, remaining, cpuEn, cmdReady);
        end
        next_cycle;
        stop = 1'b0; cmdValid = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, remaining, cpuEn} !== {2'd0, CNT_W'(0), 1'b0}) begin
            failures++;
            $display("FAIL stop_after got st=%0d rem=%0d en=%b want st=0 rem=0 en=0", state, remaining, cpuEn);
        end
        next_cycle;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || cpuEn !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_accept got st=%0d en=%b want st=0 en=0", state, cpuEn);
        end
        next_cycle;
    endtask

    task automatic test_async_reset;
        int pulses = 0;
        devide = 4'd0;
        issue(2'd3, CNT_W'(100));
        next_cycle;
        next_cycle;
        @(negedge clk);
        checks++;
        if (cpuEn !== 1'b1 || remaining !== CNT_W'(98)) begin
            failures++;
            $display("FAIL areset_pre got en=%b rem=%0d want en=1 rem=98", cpuEn, remaining);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpuEn, state, remaining, bpHit} !== '0) begin
            failures++;
            $display("FAIL areset_clear got en=%b st=%0d rem=%0d bp=%b want all zero", cpuEn, state, remaining, bpHit);
        end
        next_cycle;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpuEn || state != 2'd0) pulses++;
            next_cycle;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL areset_idle got active_cycles=%0d want 0", pulses);
        end
    endtask

    task automatic test_random;
        logic was;
        pcAddr = '0;
        for (int i = 0; i < 3000; i++) begin
            cmdValid = ($urandom_range(0, 5) == 0);
            cmdOp    = 2'($urandom_range(0, 3));
            cmdCount = CNT_W'($urandom_range(0, 5));
            stop     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) devide = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                bpEnable = 1'($urandom_range(0, 1));
                bpAddr   = 32'($urandom_range(0, 12) * 4);
            end
            @(negedge clk);
            checks++;
            if ({cpuEn, state, remaining, bpHit, cmdReady} !== {e_en, m_state, m_rem, m_bp, e_ready}) begin
                failures++;
                $display("FAIL random_cycle i=%0d got en=%b st=%0d rem=%0d bp=%b rdy=%b want en=%b st=%0d rem=%0d bp=%b rdy=%b",
                         i, cpuEn, state, remaining, bpHit, cmdReady, e_en, m_state, m_rem, m_bp, e_ready);
            end
            was = cpuEn;
            next_cycle;
            if (was) pcAddr = pcAddr + 4;
            if (pcAddr > 32'h30) pcAddr = '0;
        end
        cmdValid = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        test_reset;
        test_run;
        test_burst;
        test_breakpoint;
        test_burst_zero;
        test_stop;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
